vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Upstream timing stage for the VGA output path. Derives a pixel-rate enable from the 50 MHz system clock and runs horizontal and vertical position counters over 640x480@60 timing. Produces registered h/v sync, display-area flag, pixel coordinates and line/frame start strobes. The pixel/border drawing stage consumes these outputs directly and ANDs its colour with display_en.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); pix_en asserts once every CLK_DIV clocks
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of h_sync/v_sync (0 = active-low)

Ports:
clk  input  1  system clock (50 MHz); the only clock
rst_n  input  1  synchronous, active-low reset
pix_en  output  1  pixel-rate enable, high one clk in every CLK_DIV
counter_x  output  10  current pixel column, 0..H_TOTAL-1
counter_y  output  10  current line, 0..V_TOTAL-1
display_en  output  1  high when counter_x<H_ACTIVE and counter_y<V_ACTIVE
h_sync  output  1  horizontal sync, polarity SYNC_POL
v_sync  output  1  vertical sync, polarity SYNC_POL
line_start  output  1  one-clk strobe when counter_x becomes 0
frame_start  output  1  one-clk strobe when (counter_x,counter_y) becomes (0,0)
frame_count  output  16  frames started since reset (see Optional Feature)

Behaviour:
- One clock (clk). Reset is synchronous and active-low on rst_n; all state is sampled at posedge clk.
- Totals: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Divider: div_cnt resets to 0 and counts 0..CLK_DIV-1, wrapping to 0. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1 after reset.
- Reset values: counter_x = H_TOTAL-1, counter_y = V_TOTAL-1, display_en=0, h_sync=v_sync=~SYNC_POL (inactive), line_start=0, frame_start=0, frame_count=0. Blanking is therefore guaranteed during reset.
- Counters advance only on clk edges where pix_en=1:
  - counter_x increments.
  - At counter_x = H_TOTAL-1, counter_x wraps to 0 and counter_y increments.
  - At counter_y = V_TOTAL-1 together with counter_x wrapping, counter_y wraps to 0.
- Each axis runs a 4-state phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Transitions occur when the axis count reaches the last index of a phase. FSM state must always agree with the count; a reset forces state BACK.
- h_sync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- v_sync is active for y in [490,491], for full lines.
- display_en, h_sync and v_sync are registered from the next-count values, so they change on the same edge as the counters (zero skew, no extra latency).
- line_start and frame_start are high for exactly one clk, on the edge where the counters load 0. They are low during the remaining CLK_DIV-1 clocks of that pixel.
- A reset mid-frame takes effect on the next edge, with no partial-line completion. The first pix_en after release moves the counters to (0,0) and raises frame_start.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN:
- Defined: frame_count increments by 1 on every frame_start, wraps 0xFFFF->0, and resets to 0.
- Undefined: frame_count is tied to 0 and no counter register is built. The port list is unchanged.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 default constants (H_*/V_*);
  - derived H_TOTAL and V_TOTAL;
  - the phase typedef {ACTIVE, FRONT, SYNC, BACK}.
- Sub-module vga_axis_timing: one counter plus phase FSM with parameters ACTIVE/FP/SYNC/BP. It has an advance input and outputs count, active, sync and wrap. It is instantiated twice: the horizontal instance advances on pix_en, and the vertical instance advances on pix_en & h wrap.

Test Plan:
1. Reset release, CLK_DIV=2 -> pix_en on the 2nd clk; counters go (799,524)->(0,0); display_en=1; frame_start and line_start high exactly 1 clk.
2. One line -> display_en=1 at x=639 and 0 at x=640; h_sync low for x=656..751 (96 pixels, 192 clks); x=799->0 with counter_y +1.
3. Full frame -> v_sync low for y=490..491 (1600 pixels); (799,524)->(0,0) raises frame_start; frame period 420000 pixels / 840000 clks.
4. rst_n low for 1 clk at (300,200) -> next edge shows (799,524), display_en=0, syncs inactive; the next pix_en yields (0,0).
5. CLK_DIV=1 -> pix_en constantly 1; line period 800 clks; line_start is high 1 clk per line.
6. Macro defined: frame_count reads 0, 1, 2 at the first three frame_starts. Macro undefined: frame_count stays 0 throughout.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        PhaseActive,
        PhaseFront,
        PhaseSync,
        PhaseBack
    } phase_e;

endpackage

// File: rtl/vga_axis_timing.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// 'active' decodes the phase being loaded this edge so the top can register it without skew.
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = H_ACTIVE,
    parameter int unsigned FP       = H_FP,
    parameter int unsigned SYNC     = H_SYNC,
    parameter int unsigned BP       = H_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COUNT_W-1:0] count,
    output logic               active,
    output logic               sync,
    output logic               wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [COUNT_W-1:0] LAST_ACTIVE = COUNT_W'(ACTIVE - 1);
    localparam logic [COUNT_W-1:0] LAST_FRONT  = COUNT_W'(ACTIVE + FP - 1);
    localparam logic [COUNT_W-1:0] LAST_SYNC   = COUNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [COUNT_W-1:0] LAST        = COUNT_W'(TOTAL - 1);

    phase_e             phase_q, phase_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               sync_q, sync_d;

    // Reset parks on the last index in BACK so the first advance lands on (ACTIVE, 0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PhaseBack;
            count_q <= LAST;
            sync_q  <= ~SYNC_POL;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            unique case (phase_q)
                PhaseActive: if (count_q == LAST_ACTIVE) phase_d = PhaseFront;
                PhaseFront:  if (count_q == LAST_FRONT)  phase_d = PhaseSync;
                PhaseSync:   if (count_q == LAST_SYNC)   phase_d = PhaseBack;
                PhaseBack:   if (count_q == LAST)        phase_d = PhaseActive;
            endcase
        end
    end

    always_comb begin
        active = (phase_d == PhaseActive);
        sync_d = (phase_d == PhaseSync) ? SYNC_POL : ~SYNC_POL;
    end

    assign wrap  = (count_q == LAST);
    assign count = count_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel enable divider, h/v counters, syncs, display flag and strobes.
// Optional macro VGA_TIMING_FRAME_CNT_EN builds the frame counter behind frame_count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                pix_en,
    output logic [COUNT_W-1:0]  counter_x,
    output logic [COUNT_W-1:0]  counter_y,
    output logic                display_en,
    output logic                h_sync,
    output logic                v_sync,
    output logic                line_start,
    output logic                frame_start,
    output logic [15:0]         frame_count
);

    localparam int unsigned        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active;
    logic             v_advance;
    logic             display_en_q, line_start_q, frame_start_q;

    always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    assign pix_en    = (div_q == DIV_LAST);
    assign v_advance = pix_en & h_wrap;

    vga_axis_timing #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (pix_en),
        .count   (counter_x),
        .active  (h_active),
        .sync    (h_sync),
        .wrap    (h_wrap)
    );

    vga_axis_timing #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (v_advance),
        .count   (counter_y),
        .active  (v_active),
        .sync    (v_sync),
        .wrap    (v_wrap)
    );

    // Strobes fire on the edge that loads x=0, so they last exactly one clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            display_en_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            display_en_q  <= h_active & v_active;
            line_start_q  <= v_advance;
            frame_start_q <= v_advance & v_wrap;
        end
    end

    assign display_en  = display_en_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Counts a start once its strobe has been seen, so it reads 0 during the first strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule
